// File: rtl/data_memory_dp.sv
// Dual-port data memory. Port A is read/write with byte-lane enables, and port B is read-only.
// A clear sequencer fills every word with INIT_VAL, one word per cycle, after reset or on request.
module data_memory_dp #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                READ_LAT = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  a_we,
    input  logic [DATA_W/8-1:0]   a_be,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic [DATA_W-1:0]     a_rdata,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic [DATA_W-1:0]     b_rdata
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [NB-1:0]       w_wr_be;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (&r_clr_ptr)
                        r_state <= IDLE;
                end
                default: begin
                    if (clr_req) begin
                        r_state   <= CLEAR;
                        r_clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == CLEAR);

    // The clear sequencer owns the write port while busy; port A writes are dropped then.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = a_addr;
        w_wr_data = a_wdata;
        w_wr_be   = a_be;
        if (!rst) begin
            if (r_state == CLEAR) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_ptr;
                w_wr_data = INIT_VAL;
                w_wr_be   = '1;
            end else begin
                w_wr_en = a_we;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (w_wr_be[i])
                    r_mem[w_wr_addr][i*8 +: 8] <= w_wr_data[i*8 +: 8];
            end
        end
    end

    generate
        if (READ_LAT == 0) begin : g_comb_read
            assign a_rdata = busy ? '0 : r_mem[a_addr];
            assign b_rdata = busy ? '0 : r_mem[b_addr];
        end else begin : g_reg_read
            logic [DATA_W-1:0] r_a_rdata;
            logic [DATA_W-1:0] r_b_rdata;

            // Read-first: a same-edge write to the read address returns the old word.
            always_ff @(posedge clk) begin
                if (rst || r_state == CLEAR) begin
                    r_a_rdata <= '0;
                    r_b_rdata <= '0;
                end else begin
                    r_a_rdata <= r_mem[a_addr];
                    r_b_rdata <= r_mem[b_addr];
                end
            end

            assign a_rdata = r_a_rdata;
            assign b_rdata = r_b_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_data_memory_dp.sv
// Self-checking bench for data_memory_dp. Registered-read and combinational-read instances
// are checked side by side against an array-based reference model.
module tb_data_memory_dp;
    localparam int          DW    = 16;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [15:0] INIT  = 16'hA5A5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr_req = 1'b0;
    logic          a_we = 1'b0;
    logic [1:0]    a_be = 2'b00;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic [AW-1:0] b_addr = '0;
    logic          busy1, busy0;
    logic [DW-1:0] a_rdata1, b_rdata1, a_rdata0, b_rdata0;

    always #5 clk = ~clk;

    data_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(1), .INIT_VAL(INIT)) u_dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata1),
        .b_addr(b_addr), .b_rdata(b_rdata1)
    );

    data_memory_dp #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(0), .INIT_VAL(INIT)) u_dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata0),
        .b_addr(b_addr), .b_rdata(b_rdata0)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word array, busy flag, count of words already cleared, registered reads.
    logic [DW-1:0] m_mem [DEPTH];
    logic          m_busy = 1'b1;
    int            m_idx  = 0;
    logic [DW-1:0] m_ra = '0;
    logic [DW-1:0] m_rb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b1;
            m_idx  = 0;
            m_ra   = '0;
            m_rb   = '0;
        end else if (m_busy) begin
            m_ra = '0;
            m_rb = '0;
            m_mem[m_idx] = INIT;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 1'b0;
        end else begin
            m_ra = m_mem[a_addr];
            m_rb = m_mem[b_addr];
            if (a_we) begin
                if (a_be[0]) m_mem[a_addr][7:0]  = a_wdata[7:0];
                if (a_be[1]) m_mem[a_addr][15:8] = a_wdata[15:8];
            end
            if (clr_req) begin
                m_busy = 1'b1;
                m_idx  = 0;
            end
        end
    endtask

    // One clock: update the model at the edge, then compare every output 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("busy_lat1", {31'd0, busy1}, {31'd0, m_busy});
        check("busy_lat0", {31'd0, busy0}, {31'd0, m_busy});
        check("a_rdata_lat1", {16'd0, a_rdata1}, {16'd0, m_ra});
        check("b_rdata_lat1", {16'd0, b_rdata1}, {16'd0, m_rb});
        check("a_rdata_lat0", {16'd0, a_rdata0}, {16'd0, m_busy ? 16'h0 : m_mem[a_addr]});
        check("b_rdata_lat0", {16'd0, b_rdata0}, {16'd0, m_busy ? 16'h0 : m_mem[b_addr]});
    endtask

    // Counts busy cycles from now. clr_req is held for the first hold_clr cycles.
    // Port A writes 16'h7777 to addr 7 for the first wr_cycles cycles.
    task automatic measure_busy(input int hold_clr, input int wr_cycles, output int len);
        len = 0;
        for (int k = 0; k < 64 && busy1; k++) begin
            len++;
            clr_req = (k < hold_clr);
            a_we    = (k < wr_cycles);
            a_be    = 2'b11;
            a_addr  = 4'd7;
            a_wdata = 16'h7777;
            if (k < wr_cycles)
                check("rdata_zero_while_busy", {16'd0, a_rdata0}, 32'd0);
            cyc();
        end
        clr_req = 1'b0;
        a_we    = 1'b0;
        check("busy_drop_timeout", {31'd0, busy1}, 32'd0);
    endtask

    task automatic read_all_init(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            a_addr = AW'(i);
            b_addr = AW'(DEPTH - 1 - i);
            cyc();
            check(name, {16'd0, a_rdata1}, {16'd0, INIT});
            check(name, {16'd0, b_rdata0}, {16'd0, INIT});
        end
    endtask

    typedef struct {
        logic          we;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] baddr;
        logic [DW-1:0] exp_a1;
        logic [DW-1:0] exp_b1;
        logic [DW-1:0] exp_a0;
        logic [DW-1:0] exp_b0;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int len;

        vecs[0] = '{1'b1, 2'b11, 4'd3, 16'h1234, 4'd3, 16'hA5A5, 16'hA5A5, 16'h1234, 16'h1234};
        vecs[1] = '{1'b1, 2'b10, 4'd3, 16'hFF00, 4'd3, 16'h1234, 16'h1234, 16'hFF34, 16'hFF34};
        vecs[2] = '{1'b1, 2'b00, 4'd3, 16'h0000, 4'd3, 16'hFF34, 16'hFF34, 16'hFF34, 16'hFF34};
        vecs[3] = '{1'b0, 2'b00, 4'd3, 16'h0000, 4'd3, 16'hFF34, 16'hFF34, 16'hFF34, 16'hFF34};
        vecs[4] = '{1'b1, 2'b11, 4'd5, 16'hBEEF, 4'd5, 16'hA5A5, 16'hA5A5, 16'hBEEF, 16'hBEEF};
        vecs[5] = '{1'b0, 2'b00, 4'd5, 16'h0000, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[6] = '{1'b1, 2'b01, 4'd5, 16'h0011, 4'd3, 16'hBEEF, 16'hFF34, 16'hBE11, 16'hFF34};
        vecs[7] = '{1'b0, 2'b00, 4'd5, 16'h0000, 4'd5, 16'hBE11, 16'hBE11, 16'hBE11, 16'hBE11};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Reset clear: a one-cycle rst pulse gives exactly DEPTH busy cycles.
        rst = 1'b1;
        cyc();
        check("busy_during_rst", {31'd0, busy1}, 32'd1);
        rst = 1'b0;
        measure_busy(0, 0, len);
        check("reset_clear_len", len, DEPTH);
        read_all_init("reset_clear_init");

        // Table-driven vectors: byte enables and read latency.
        for (int v = 0; v < 8; v++) begin
            a_we    = vecs[v].we;
            a_be    = vecs[v].be;
            a_addr  = vecs[v].addr;
            a_wdata = vecs[v].wdata;
            b_addr  = vecs[v].baddr;
            cyc();
            check($sformatf("vec%0d_a1", v), {16'd0, a_rdata1}, {16'd0, vecs[v].exp_a1});
            check($sformatf("vec%0d_b1", v), {16'd0, b_rdata1}, {16'd0, vecs[v].exp_b1});
            check($sformatf("vec%0d_a0", v), {16'd0, a_rdata0}, {16'd0, vecs[v].exp_a0});
            check($sformatf("vec%0d_b0", v), {16'd0, b_rdata0}, {16'd0, vecs[v].exp_b0});
        end
        a_we = 1'b0;

        // Writes blocked in CLEAR: clr_req, then three attempted writes to addr 7.
        a_we = 1'b1; a_be = 2'b11; a_addr = 4'd7; a_wdata = 16'h1111;
        clr_req = 1'b1;
        cyc();
        measure_busy(0, 3, len);
        check("clr_req_len", len, DEPTH);
        a_addr = 4'd7;
        cyc();
        check("addr7_blocked", {16'd0, a_rdata1}, {16'd0, INIT});

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            clr_req = ($urandom_range(0, 59) == 0);
            a_we    = $urandom_range(0, 1) == 1;
            a_be    = 2'($urandom_range(0, 3));
            a_addr  = AW'($urandom_range(0, DEPTH - 1));
            b_addr  = AW'($urandom_range(0, DEPTH - 1));
            a_wdata = DW'($urandom);
            cyc();
        end
        rst = 1'b0; clr_req = 1'b0; a_we = 1'b0;
        measure_busy(0, 0, len);
        for (int i = 0; i < DEPTH; i++) begin
            a_we = 1'b1; a_be = 2'b11; a_addr = AW'(i); a_wdata = DW'($urandom);
            cyc();
        end
        a_we = 1'b0;

        // Reset mid-clear at clr_ptr=9 restarts the full sequence.
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        measure_busy(0, 0, len);
        check("rst_mid_clear_len", len, DEPTH);
        read_all_init("rst_mid_clear_init");

        // clr_req while busy does not extend the sequence.
        clr_req = 1'b1;
        cyc();
        measure_busy(10, 0, len);
        check("clr_req_busy_len", len, DEPTH);
        cyc();
        check("idle_after_clear", {31'd0, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
